// File: rtl/btu_inverse.sv
// Inverse bit-transpose unit: buffers R bit-plane rows, then streams the repacked word block.
// Optional row_last/err_len length check is enabled by defining BTU_INV_ROWLAST_CHECK_EN.
module btu_inverse #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int MAX_ROWS   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [4:0]                   cmd_n,
  input  logic                         row_valid,
  output logic                         row_ready,
  input  logic [NUM_WORDS-1:0]         row_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [DATA_WIDTH-1:0]        word_data,
  output logic [$clog2(NUM_WORDS)-1:0] word_idx,
  output logic                         word_last,
  output logic                         busy,
  output logic                         err_n
`ifdef BTU_INV_ROWLAST_CHECK_EN
  ,
  input  logic                         row_last,
  output logic                         err_len
`endif
);

  localparam int ROW_W = $clog2(MAX_ROWS);
  localparam int CNT_W = $clog2(MAX_ROWS + 1);
  localparam int IDX_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             n_q, n_d;
  logic [CNT_W-1:0]       rows_q, rows_d;
  logic [CNT_W-1:0]       row_cnt_q, row_cnt_d;
  logic [NUM_WORDS-1:0]   row_buf_q [MAX_ROWS];
  logic [NUM_WORDS-1:0]   row_buf_d [MAX_ROWS];
  logic                   word_valid_q, word_valid_d;
  logic [IDX_W-1:0]       word_idx_q, word_idx_d;
  logic                   err_n_q, err_n_d;
`ifdef BTU_INV_ROWLAST_CHECK_EN
  logic                   err_len_q, err_len_d;
`endif

  logic                   cmd_legal;
  logic [CNT_W-1:0]       cmd_rows;
  logic                   row_is_last;
  logic                   last_word;
  logic [DATA_WIDTH-1:0]  asm_word;

  assign cmd_legal   = (cmd_n != 5'd0) && (cmd_n <= 5'd16);
  assign cmd_rows    = (cmd_n >= 5'd9) ? (CNT_W'(cmd_n) << 1) : (CNT_W'(cmd_n) << 2);
  assign row_is_last = (row_cnt_q == (rows_q - CNT_W'(1)));
  assign last_word   = (word_idx_q == IDX_W'(NUM_WORDS - 1));

  // Column w of the row buffer holds word w; rows are spread over 2 (n>=9) or 4 byte lanes.
  always_comb begin
    logic [ROW_W-1:0] ridx;
    ridx     = '0;
    asm_word = '0;
    if (n_q >= 5'd9) begin
      for (int b = 0; b < 16; b++) begin
        if (b < int'(n_q)) begin
          ridx             = ROW_W'(b);
          asm_word[16 + b] = row_buf_q[ridx][word_idx_q];
          ridx             = ROW_W'(b + int'(n_q));
          asm_word[b]      = row_buf_q[ridx][word_idx_q];
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 8; b++) begin
          if (b < int'(n_q)) begin
            ridx                      = ROW_W'(k * int'(n_q) + b);
            asm_word[8 * (3 - k) + b] = row_buf_q[ridx][word_idx_q];
          end
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    rows_d       = rows_q;
    row_cnt_d    = row_cnt_q;
    row_buf_d    = row_buf_q;
    word_valid_d = word_valid_q;
    word_idx_d   = word_idx_q;
    err_n_d      = 1'b0;
`ifdef BTU_INV_ROWLAST_CHECK_EN
    err_len_d    = err_len_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal) begin
            n_d       = cmd_n;
            rows_d    = cmd_rows;
            row_cnt_d = '0;
            state_d   = LOAD;
`ifdef BTU_INV_ROWLAST_CHECK_EN
            err_len_d = 1'b0;
`endif
          end else begin
            err_n_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (row_valid) begin
          row_buf_d[row_cnt_q[ROW_W-1:0]] = row_data;
          row_cnt_d = row_cnt_q + CNT_W'(1);
`ifdef BTU_INV_ROWLAST_CHECK_EN
          if (row_last != row_is_last) err_len_d = 1'b1;
`endif
          if (row_is_last) begin
            state_d      = EMIT;
            word_valid_d = 1'b1;
            word_idx_d   = '0;
          end
        end
      end
      EMIT: begin
        if (word_ready) begin
          word_idx_d = word_idx_q + IDX_W'(1);
          if (last_word) begin
            state_d      = IDLE;
            word_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      rows_q       <= '0;
      row_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_idx_q   <= '0;
      err_n_q      <= 1'b0;
`ifdef BTU_INV_ROWLAST_CHECK_EN
      err_len_q    <= 1'b0;
`endif
      for (int r = 0; r < MAX_ROWS; r++) row_buf_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      rows_q       <= rows_d;
      row_cnt_q    <= row_cnt_d;
      word_valid_q <= word_valid_d;
      word_idx_q   <= word_idx_d;
      err_n_q      <= err_n_d;
`ifdef BTU_INV_ROWLAST_CHECK_EN
      err_len_q    <= err_len_d;
`endif
      for (int r = 0; r < MAX_ROWS; r++) row_buf_q[r] <= row_buf_d[r];
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign row_ready  = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign word_valid = word_valid_q;
  assign word_idx   = word_idx_q;
  assign word_last  = word_valid_q && last_word;
  assign word_data  = word_valid_q ? asm_word : '0;
  assign err_n      = err_n_q;
`ifdef BTU_INV_ROWLAST_CHECK_EN
  assign err_len    = err_len_q;
`endif

endmodule

// File: tb/tb_btu_inverse.sv
// Self-checking bench for btu_inverse: directed patterns plus randomized blocks checked
// against a column-value reference model of the inverse packing.
module tb_btu_inverse;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_n;
  logic        row_valid;
  logic        row_ready;
  logic [31:0] row_data;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [4:0]  word_idx;
  logic        word_last;
  logic        busy;
  logic        err_n;
`ifdef BTU_INV_ROWLAST_CHECK_EN
  logic        row_last;
  logic        err_len;
`endif

  int vectors;
  int miscompares;

  logic [31:0] blk_rows [32];
  logic [31:0] obs_word [32];
  logic [4:0]  obs_idx  [32];
  logic        obs_last [32];
  int          rl_bad_row;

  btu_inverse dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_n      (cmd_n),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .busy       (busy),
    .err_n      (err_n)
`ifdef BTU_INV_ROWLAST_CHECK_EN
    ,
    .row_last   (row_last),
    .err_len    (err_len)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: gather word w's column as an integer over rows, then slice it into lanes.
  function automatic logic [31:0] model_word(int n, int w);
    logic [63:0] v;
    logic [63:0] mask;
    logic [31:0] res;
    int          r_tot;
    v     = '0;
    res   = '0;
    r_tot = (n >= 9) ? 2 * n : 4 * n;
    mask  = (64'd1 << n) - 64'd1;
    for (int r = 0; r < r_tot; r++) if (blk_rows[r][w]) v[r] = 1'b1;
    if (n >= 9) res = 32'(((v & mask) << 16) | ((v >> n) & mask));
    else for (int k = 0; k < 4; k++) res = res | 32'(((v >> (k * n)) & mask) << (8 * (3 - k)));
    return res;
  endfunction

  task automatic run_block(input int n, input bit rand_v, input bit rand_r,
                           output int rows_acc, output bit valid_after, output bit rready_after,
                           output bit cready_after, output int proto_err, output bit timeout);
    int          r_tot;
    int          ri;
    int          wi;
    int          cyc;
    bit          hs;
    bit          pstall;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic        pl;
    r_tot     = (n >= 9) ? 2 * n : 4 * n;
    ri        = 0;
    wi        = 0;
    pstall    = 1'b0;
    pd        = '0;
    pi        = '0;
    pl        = 1'b0;
    proto_err = 0;
    timeout   = 1'b0;
    @(negedge clk);
    cmd_n     = 5'(n);
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cmd_n = 5'($urandom_range(1, 16));
    cyc = 0;
    while (ri < r_tot && cyc < 2000) begin
      row_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
      row_data  = row_valid ? blk_rows[ri] : $urandom;
`ifdef BTU_INV_ROWLAST_CHECK_EN
      row_last  = (rl_bad_row >= 0) ? (ri == rl_bad_row) : (ri == r_tot - 1);
`endif
      if (word_valid) proto_err++;
      hs = row_valid && row_ready;
      @(negedge clk);
      cyc++;
      if (hs) ri++;
    end
    rows_acc     = ri;
    if (ri < r_tot) timeout = 1'b1;
    valid_after  = word_valid;
    rready_after = row_ready;
    cmd_valid    = 1'b0;
    row_valid    = 1'b1;
    row_data     = $urandom;
`ifdef BTU_INV_ROWLAST_CHECK_EN
    row_last     = 1'b0;
`endif
    cyc = 0;
    while (wi < 32 && cyc < 2000) begin
      word_ready = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pstall && !word_valid) proto_err++;
      if (pstall && word_valid && (word_data !== pd || word_idx !== pi || word_last !== pl))
        proto_err++;
      hs = word_valid && word_ready;
      if (hs) begin
        obs_word[wi] = word_data;
        obs_idx[wi]  = word_idx;
        obs_last[wi] = word_last;
        wi++;
      end
      pstall = word_valid && !word_ready;
      pd     = word_data;
      pi     = word_idx;
      pl     = word_last;
      @(negedge clk);
      cyc++;
    end
    if (wi < 32) timeout = 1'b1;
    cready_after = cmd_ready;
    word_ready   = 1'b0;
    row_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 3;
    if ({cmd_ready, row_ready, word_valid, word_last, busy, err_n} !== 6'b100000) begin
      $display("[TB] FAIL reset_flags: got %b expected 100000",
               {cmd_ready, row_ready, word_valid, word_last, busy, err_n});
      miscompares++;
    end
    if (word_data !== 32'h0) begin
      $display("[TB] FAIL reset_word_data: got %h expected 00000000", word_data);
      miscompares++;
    end
    if (word_idx !== 5'd0) begin
      $display("[TB] FAIL reset_word_idx: got %0d expected 0", word_idx);
      miscompares++;
    end
    rst = 1'b0;
  endtask

  task automatic test_n4_pattern();
    int rows_acc, proto_err;
    bit valid_after, rready_after, cready_after, timeout;
    for (int r = 0; r < 32; r++) blk_rows[r] = 32'h0;
    foreach (blk_rows[r]) if (r == 0 || r == 3 || r == 4 || r == 7 || r == 8 || r == 11 || r == 12 || r == 15)
      blk_rows[r] = 32'hFFFF_FFFF;
    run_block(4, 1'b0, 1'b0, rows_acc, valid_after, rready_after, cready_after, proto_err, timeout);
    vectors += 5;
    if (timeout || rows_acc != 16) begin
      $display("[TB] FAIL n4_rows: got %0d rows (timeout %0d) expected 16", rows_acc, timeout);
      miscompares++;
    end
    if (valid_after !== 1'b1) begin
      $display("[TB] FAIL n4_first_valid: got %b expected 1 one cycle after last row", valid_after);
      miscompares++;
    end
    if (rready_after !== 1'b0) begin
      $display("[TB] FAIL n4_row_ready_after: got %b expected 0", rready_after);
      miscompares++;
    end
    if (proto_err != 0) begin
      $display("[TB] FAIL n4_protocol: got %0d violations expected 0", proto_err);
      miscompares++;
    end
    if (cready_after !== 1'b1) begin
      $display("[TB] FAIL n4_cmd_ready_after: got %b expected 1", cready_after);
      miscompares++;
    end
    for (int w = 0; w < 32; w++) begin
      vectors += 3;
      if (obs_word[w] !== 32'h0909_0909) begin
        $display("[TB] FAIL n4_word[%0d]: got %h expected 09090909", w, obs_word[w]);
        miscompares++;
      end
      if (obs_idx[w] !== 5'(w)) begin
        $display("[TB] FAIL n4_idx[%0d]: got %0d expected %0d", w, obs_idx[w], w);
        miscompares++;
      end
      if (obs_last[w] !== (w == 31)) begin
        $display("[TB] FAIL n4_last[%0d]: got %b expected %b", w, obs_last[w], (w == 31));
        miscompares++;
      end
    end
  endtask

  task automatic test_n9_pattern();
    int rows_acc, proto_err;
    bit valid_after, rready_after, cready_after, timeout;
    for (int r = 0; r < 32; r++) blk_rows[r] = 32'h0;
    blk_rows[0]  = 32'hFFFF_FFFF;
    blk_rows[8]  = 32'hFFFF_FFFF;
    blk_rows[9]  = 32'hFFFF_FFFF;
    blk_rows[17] = 32'hFFFF_FFFF;
    run_block(9, 1'b0, 1'b0, rows_acc, valid_after, rready_after, cready_after, proto_err, timeout);
    vectors += 3;
    if (timeout || rows_acc != 18) begin
      $display("[TB] FAIL n9_rows: got %0d rows (timeout %0d) expected 18", rows_acc, timeout);
      miscompares++;
    end
    if (rready_after !== 1'b0 || valid_after !== 1'b1) begin
      $display("[TB] FAIL n9_after_rows: got row_ready %b word_valid %b expected 0 1",
               rready_after, valid_after);
      miscompares++;
    end
    if (proto_err != 0 || cready_after !== 1'b1) begin
      $display("[TB] FAIL n9_protocol: got %0d violations cmd_ready %b expected 0 1",
               proto_err, cready_after);
      miscompares++;
    end
    for (int w = 0; w < 32; w++) begin
      vectors += 2;
      if (obs_word[w] !== 32'h0101_0101) begin
        $display("[TB] FAIL n9_word[%0d]: got %h expected 01010101", w, obs_word[w]);
        miscompares++;
      end
      if (obs_idx[w] !== 5'(w) || obs_last[w] !== (w == 31)) begin
        $display("[TB] FAIL n9_idx_last[%0d]: got %0d/%b expected %0d/%b",
                 w, obs_idx[w], obs_last[w], w, (w == 31));
        miscompares++;
      end
    end
  endtask

  task automatic test_random_blocks();
    int rows_acc, proto_err, n, r_tot;
    bit valid_after, rready_after, cready_after, timeout;
    logic [31:0] exp_w;
    for (int t = 0; t < 24; t++) begin
      case (t)
        0:       n = 1;
        1:       n = 8;
        2:       n = 9;
        3:       n = 16;
        default: n = $urandom_range(1, 16);
      endcase
      r_tot = (n >= 9) ? 2 * n : 4 * n;
      for (int r = 0; r < 32; r++) blk_rows[r] = $urandom;
      run_block(n, 1'b1, 1'b1, rows_acc, valid_after, rready_after, cready_after, proto_err, timeout);
      vectors += 2;
      if (timeout || rows_acc != r_tot || rready_after !== 1'b0) begin
        $display("[TB] FAIL rand_rows n=%0d: got %0d rows row_ready %b (timeout %0d) expected %0d rows row_ready 0",
                 n, rows_acc, rready_after, timeout, r_tot);
        miscompares++;
      end
      if (proto_err != 0 || valid_after !== 1'b1 || cready_after !== 1'b1) begin
        $display("[TB] FAIL rand_protocol n=%0d: got %0d violations valid %b cmd_ready %b expected 0 1 1",
                 n, proto_err, valid_after, cready_after);
        miscompares++;
      end
      for (int w = 0; w < 32; w++) begin
        exp_w = model_word(n, w);
        vectors += 2;
        if (obs_word[w] !== exp_w) begin
          $display("[TB] FAIL rand_word n=%0d [%0d]: got %h expected %h", n, w, obs_word[w], exp_w);
          miscompares++;
        end
        if (obs_idx[w] !== 5'(w) || obs_last[w] !== (w == 31)) begin
          $display("[TB] FAIL rand_idx_last n=%0d [%0d]: got %0d/%b expected %0d/%b",
                   n, w, obs_idx[w], obs_last[w], w, (w == 31));
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_illegal_n();
    int rows_acc, proto_err;
    bit valid_after, rready_after, cready_after, timeout;
    logic [31:0] exp_w;
    int bad_n [2] = '{0, 17};
    foreach (bad_n[i]) begin
      @(negedge clk);
      cmd_n     = 5'(bad_n[i]);
      cmd_valid = 1'b1;
      row_valid = 1'b1;
      row_data  = $urandom;
      @(negedge clk);
      cmd_valid = 1'b0;
      vectors += 2;
      if (err_n !== 1'b1) begin
        $display("[TB] FAIL illegal_err_n n=%0d: got %b expected 1", bad_n[i], err_n);
        miscompares++;
      end
      if ({busy, row_ready, cmd_ready} !== 3'b001) begin
        $display("[TB] FAIL illegal_state n=%0d: got busy/row_ready/cmd_ready %b expected 001",
                 bad_n[i], {busy, row_ready, cmd_ready});
        miscompares++;
      end
      @(negedge clk);
      vectors += 1;
      if ({err_n, busy, row_ready} !== 3'b000) begin
        $display("[TB] FAIL illegal_pulse_end n=%0d: got err_n/busy/row_ready %b expected 000",
                 bad_n[i], {err_n, busy, row_ready});
        miscompares++;
      end
      row_valid = 1'b0;
    end
    for (int r = 0; r < 32; r++) blk_rows[r] = $urandom;
    run_block(16, 1'b0, 1'b1, rows_acc, valid_after, rready_after, cready_after, proto_err, timeout);
    vectors += 1;
    if (timeout || rows_acc != 32 || proto_err != 0) begin
      $display("[TB] FAIL after_illegal_block: got %0d rows %0d violations expected 32 0", rows_acc, proto_err);
      miscompares++;
    end
    for (int w = 0; w < 32; w++) begin
      exp_w = model_word(16, w);
      vectors += 1;
      if (obs_word[w] !== exp_w) begin
        $display("[TB] FAIL after_illegal_word[%0d]: got %h expected %h", w, obs_word[w], exp_w);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int rows_acc, proto_err;
    bit valid_after, rready_after, cready_after, timeout;
    logic [31:0] exp_w;
    @(negedge clk);
    cmd_n     = 5'd4;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    row_valid = 1'b1;
    repeat (5) begin
      row_data = $urandom;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors += 3;
    if ({cmd_ready, row_ready, word_valid, word_last, busy, err_n} !== 6'b100000) begin
      $display("[TB] FAIL midrst_flags: got %b expected 100000",
               {cmd_ready, row_ready, word_valid, word_last, busy, err_n});
      miscompares++;
    end
    if (word_data !== 32'h0 || word_idx !== 5'd0) begin
      $display("[TB] FAIL midrst_word: got %h/%0d expected 00000000/0", word_data, word_idx);
      miscompares++;
    end
    rst       = 1'b0;
    row_valid = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0) begin
      $display("[TB] FAIL midrst_idle: got busy %b expected 0", busy);
      miscompares++;
    end
    for (int r = 0; r < 32; r++) blk_rows[r] = $urandom;
    run_block(4, 1'b1, 1'b1, rows_acc, valid_after, rready_after, cready_after, proto_err, timeout);
    vectors += 1;
    if (timeout || rows_acc != 16 || proto_err != 0) begin
      $display("[TB] FAIL midrst_block: got %0d rows %0d violations expected 16 0", rows_acc, proto_err);
      miscompares++;
    end
    for (int w = 0; w < 32; w++) begin
      exp_w = model_word(4, w);
      vectors += 1;
      if (obs_word[w] !== exp_w) begin
        $display("[TB] FAIL midrst_word[%0d]: got %h expected %h", w, obs_word[w], exp_w);
        miscompares++;
      end
    end
  endtask

`ifdef BTU_INV_ROWLAST_CHECK_EN
  task automatic test_row_last_check();
    int rows_acc, proto_err;
    bit valid_after, rready_after, cready_after, timeout;
    logic [31:0] exp_w;
    vectors += 1;
    if (err_len !== 1'b0) begin
      $display("[TB] FAIL errlen_initial: got %b expected 0", err_len);
      miscompares++;
    end
    for (int r = 0; r < 32; r++) blk_rows[r] = $urandom;
    rl_bad_row = 10;
    run_block(4, 1'b0, 1'b1, rows_acc, valid_after, rready_after, cready_after, proto_err, timeout);
    rl_bad_row = -1;
    vectors += 2;
    if (err_len !== 1'b1) begin
      $display("[TB] FAIL errlen_set: got %b expected 1", err_len);
      miscompares++;
    end
    if (timeout || rows_acc != 16 || rready_after !== 1'b0) begin
      $display("[TB] FAIL errlen_rows: got %0d rows row_ready %b expected 16 0", rows_acc, rready_after);
      miscompares++;
    end
    for (int w = 0; w < 32; w++) begin
      exp_w = model_word(4, w);
      vectors += 1;
      if (obs_word[w] !== exp_w) begin
        $display("[TB] FAIL errlen_word[%0d]: got %h expected %h", w, obs_word[w], exp_w);
        miscompares++;
      end
    end
    @(negedge clk);
    cmd_n     = 5'd4;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors += 1;
    if (err_len !== 1'b0 || row_ready !== 1'b1) begin
      $display("[TB] FAIL errlen_clear: got err_len %b row_ready %b expected 0 1", err_len, row_ready);
      miscompares++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rl_bad_row  = -1;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_n       = 5'd0;
    row_valid   = 1'b0;
    row_data    = 32'h0;
    word_ready  = 1'b0;
`ifdef BTU_INV_ROWLAST_CHECK_EN
    row_last    = 1'b0;
`endif
    test_reset();
    test_n4_pattern();
    test_n9_pattern();
    test_random_blocks();
    test_illegal_n();
    test_reset_mid_load();
`ifdef BTU_INV_ROWLAST_CHECK_EN
    test_row_last_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
